rr_grant_scheduler8: RTL
========================

Name: rr_grant_scheduler8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Registers a one-hot grant and a 3-bit binary grant index. Optionally also produces the 4-bit Gray-style grant code used by the 8-input encoder datapath.
- Grants are held until the owner releases or a hold timer expires.
- Sits between the requester bank and the shared encoder/bus resource.

Parameters:
- MAX_HOLD, 16: maximum cycles one owner may hold a grant; legal range 2..255.
- HOLD_W, $clog2(MAX_HOLD+1): hold counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req  in  8  request lines; req[i] must stay high until granted.
- done  in  1  owner release pulse; sampled only in BUSY.
- gnt  out  8  one-hot grant, registered.
- gnt_valid  out  1  high when gnt is non-zero.
- gnt_idx  out  3  binary index of the owner; 0 when not valid.
- timeout  out  1  one-cycle pulse on forced release.
- gnt_code  out  4  present only with ARB_GRANT_CODE_EN (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0.
  - ptr=0, hold_cnt=0.
  - Applies from any state, including mid-grant; no release pulse is emitted.
- States: IDLE, BUSY, TURN.
- IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - Register the one-hot grant and index, clear hold_cnt, go to BUSY.
  - Latency: req sampled at edge k gives gnt visible after edge k.
  - If req==0, stay in IDLE with outputs 0.
- BUSY:
  - hold_cnt increments each cycle.
  - Release when done=1, or req[gnt_idx]=0, or hold_cnt==MAX_HOLD-1.
  - On release: ptr <= gnt_idx+1 (mod 8, 3-bit wrap 7->0), gnt cleared, go to TURN.
  - timeout=1 for exactly one cycle only when release is caused solely by hold expiry.
  - If done or req drop coincides with expiry, this is a normal release and timeout=0.
- TURN:
  - One dead cycle with gnt=0, giving a guaranteed bus turnaround, then IDLE.
  - Requests arriving in TURN are served from IDLE on the next cycle.
- Consequences:
  - Minimum grant-to-grant spacing is 3 cycles.
  - gnt is never multi-hot; gnt_valid equals |gnt.
  - req changes of non-owners while BUSY are ignored.
  - req=8'hFF held constantly produces grant order 0,1,...,7,0,...

Optional Feature:
- Macro ARB_GRANT_CODE_EN.
- Defined:
  - Port gnt_code[3:0] exists, registered alongside gnt.
  - With n = 8 - gnt_idx (4-bit), gnt_code = n ^ (n>>1).
  - Mapping idx7..idx0 -> 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
  - gnt_code = 0000 when gnt_valid=0 and after reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rr_sched_pkg holds:
  - state_t enum {IDLE, BUSY, TURN}.
  - localparam N_REQ=8 and IDX_W=3.
  - Function gray_code4(idx) used by the optional output.
- Sub-module rr_pick8: combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0], onehot[7:0].
  - Instantiated once in the top.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- req=8'h80 at cycle 2, done pulse at cycle 5:
  - gnt=8'h80 and gnt_idx=7 from after edge 2.
  - Cleared after edge 5, TURN one cycle.
  - ptr wraps to 0.
  - gnt_code=0001 with ARB_GRANT_CODE_EN.
- req=8'hFF constant, done pulsed 1 cycle after each grant -> grant sequence idx 0,1,2,...,7,0, spacing 3 cycles.
- req=8'h04 held, no done, MAX_HOLD=16:
  - Released after 16 BUSY cycles, timeout=1 for one cycle.
  - Re-granted idx 2 after TURN and IDLE.
- Owner idx 3 with done and expiry in the same cycle -> release, timeout stays 0; next grant searches from ptr=4.
- rst asserted mid-BUSY (gnt=8'h10):
  - Next cycle gnt=0 and ptr=0.
  - With req=8'h11 afterwards, idx 0 is granted first.

Source files
------------

// File: rtl/rr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sched_pkg
//  Purpose  : Shared types, sizes and helpers for the rr_grant_scheduler8
//             round-robin arbiter (FSM state type, requester count, index
//             width, optional 4-bit grant code encoder).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rr_sched_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_t;

   // Code consumed by the 8-input encoder datapath: n = 8 - idx, then
   // binary-reflected Gray of n. idx0 -> 1100 ... idx7 -> 0001.
   function automatic logic [3:0] gray_code4(input logic [IDX_W-1:0] idx);
      logic [3:0] n;
      n = 4'd8 - {1'b0, idx};
      return n ^ (n >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant_scheduler8_if.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler8_if
//  Purpose  : Requester-bank <-> scheduler signal bundle.
//  Signals  : req[7:0], done        driven by the requester side (master)
//             gnt[7:0], gnt_valid,
//             gnt_idx[2:0], timeout driven by the scheduler (slave)
//             gnt_code[3:0]         only when ARB_GRANT_CODE_EN is defined
//  Macro    : ARB_GRANT_CODE_EN
//  Revision : 1.0  initial release
// ============================================================================
interface rr_grant_scheduler8_if;
   import rr_sched_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic             timeout;
`ifdef ARB_GRANT_CODE_EN
   logic [3:0]       gnt_code;
`endif

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_valid,
      input  gnt_idx,
`ifdef ARB_GRANT_CODE_EN
      input  gnt_code,
`endif
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_valid,
      output gnt_idx,
`ifdef ARB_GRANT_CODE_EN
      output gnt_code,
`endif
      output timeout
   );

endinterface
`default_nettype wire

// File: rtl/rr_pick8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick8
//  Purpose  : Combinational rotate-priority picker. Finds the first set
//             request searching ptr, ptr+1, ..., 7, 0, ..., ptr-1.
//  Ports    : req_i[7:0]    request vector
//             ptr_i[2:0]    highest-priority position
//             any_o         at least one request set
//             idx_o[2:0]    winning index (0 when any_o=0)
//             onehot_o[7:0] winning one-hot (0 when any_o=0)
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick8
   import rr_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             any_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [N_REQ-1:0] onehot_o
);

   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]   w_off;

   // Rotate so that position ptr lands at bit 0; a fixed lowest-bit-wins
   // search on the rotated vector is then the round-robin search.
   assign w_dbl = {req_i, req_i};
   assign w_rot = w_dbl[ptr_i +: N_REQ];

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      w_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = IDX_W'(i);
         end
      end
   end

   assign any_o    = |req_i;
   assign idx_o    = any_o ? (ptr_i + w_off) : '0;   // 3-bit add wraps mod 8
   assign onehot_o = any_o ? (N_REQ'(1) << idx_o) : '0;

endmodule
`default_nettype wire

// File: rtl/rr_grant_scheduler8.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_scheduler8
//  Purpose  : 8-requester round-robin arbiter for one shared resource.
//             IDLE picks an owner, BUSY holds the grant until done, owner
//             request drop, or hold expiry, TURN inserts one dead cycle.
//  Ports    : clk           rising-edge clock
//             rst           synchronous active-high reset
//             bus (slave)   req/done in; gnt, gnt_valid, gnt_idx, timeout
//                           out; gnt_code out with ARB_GRANT_CODE_EN
//  Params   : MAX_HOLD      max cycles one owner may hold (2..255)
//  Macro    : ARB_GRANT_CODE_EN  adds registered 4-bit gnt_code output
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_scheduler8
   import rr_sched_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   rr_grant_scheduler8_if.slave  bus
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   state_t            state_q,   state_d;
   logic [N_REQ-1:0]  gnt_q,     gnt_d;
   logic [IDX_W-1:0]  idx_q,     idx_d;
   logic [IDX_W-1:0]  ptr_q,     ptr_d;
   logic [HOLD_W-1:0] hold_q,    hold_d;
   logic              timeout_q, timeout_d;
`ifdef ARB_GRANT_CODE_EN
   logic [3:0]        code_q,    code_d;
`endif

   logic              w_any;
   logic [IDX_W-1:0]  w_pick_idx;
   logic [N_REQ-1:0]  w_pick_onehot;
   logic              w_normal_rel;
   logic              w_expire;

   rr_pick8 u_pick (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .any_o    (w_any),
      .idx_o    (w_pick_idx),
      .onehot_o (w_pick_onehot)
   );

   // Owner-initiated release (done or dropped request) outranks expiry so
   // that a coincident expiry is not reported as a timeout.
   assign w_normal_rel = bus.done || !bus.req[idx_q];
   assign w_expire     = (hold_q == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
`ifdef ARB_GRANT_CODE_EN
         code_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`ifdef ARB_GRANT_CODE_EN
         code_q    <= code_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
`ifdef ARB_GRANT_CODE_EN
      code_d    = code_q;
`endif
      case (state_q)
         IDLE: begin
            if (w_any) begin
               gnt_d   = w_pick_onehot;
               idx_d   = w_pick_idx;
               hold_d  = '0;
               state_d = BUSY;
`ifdef ARB_GRANT_CODE_EN
               code_d  = gray_code4(w_pick_idx);
`endif
            end
         end
         BUSY: begin
            if (w_normal_rel || w_expire) begin
               gnt_d     = '0;
               idx_d     = '0;
               hold_d    = '0;
               ptr_d     = idx_q + IDX_W'(1);
               timeout_d = !w_normal_rel;
               state_d   = TURN;
`ifdef ARB_GRANT_CODE_EN
               code_d    = '0;
`endif
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.timeout   = timeout_q;
`ifdef ARB_GRANT_CODE_EN
   assign bus.gnt_code  = code_q;
`endif

endmodule
`default_nettype wire
